// File: rtl/cache_pkg.sv
// Shared cache-path definitions: line geometry and the write-back FSM state type,
// used by the write-back engine, the line-fill adapter and the cache controller.
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int OFFSET_BITS    = 5;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_DONE  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_next_dirty.sv
// Priority encoder for the dirty-mask build (WB_DIRTY_MASK_EN): lowest dirty index above
// cur_idx (or at it, when incl_cur is set), plus a flag saying whether one exists.
`ifdef WB_DIRTY_MASK_EN
module wb_next_dirty #(
    parameter int WORDS_PER_LINE = 8,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic [WORDS_PER_LINE-1:0] mask,
    input  logic [IDX_W-1:0]          cur_idx,
    input  logic                      incl_cur,
    output logic [IDX_W-1:0]          nxt_idx,
    output logic                      nxt_vld
);

    // Scan from the top down so the lowest qualifying index is the one left standing.
    always_comb begin
        nxt_idx = '0;
        nxt_vld = 1'b0;
        for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur_idx)) || (incl_cur && (i == int'(cur_idx))))) begin
                nxt_idx = IDX_W'(i);
                nxt_vld = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cache_line_writeback.sv
// Write-back engine: serialises one evicted 256-bit line into 32-bit memory writes.
// Optional WB_DIRTY_MASK_EN adds wbDirty so that only dirty words are written.
module cache_line_writeback #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 32
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             wbStart,
    input  logic [ADDR_W-1:0]                wbAddr,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] wbLine,
`ifdef WB_DIRTY_MASK_EN
    input  logic [WORDS_PER_LINE-1:0]        wbDirty,
`endif
    output logic                             wbBusy,
    output logic                             wbDone,
    output logic                             memWE,
    output logic [ADDR_W-1:0]                memAddr,
    output logic [WORD_W-1:0]                memDout,
    input  logic                             memAck
);

    import cache_pkg::*;

    localparam int IDX_W     = $clog2(WORDS_PER_LINE);
    localparam int BASE_W    = ADDR_W - OFFSET_BITS;
    localparam int LINE_BITS = WORD_W * WORDS_PER_LINE;

    wb_state_t              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BASE_W-1:0]      base_q, base_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]      mem_dout_q, mem_dout_d;

    logic [IDX_W-1:0]       first_idx, next_idx;
    logic                   first_vld, next_vld;
    logic                   addr_lsb_unused;

    assign addr_lsb_unused = ^wbAddr[OFFSET_BITS-1:0];

    function automatic logic [WORD_W-1:0] word_of(input logic [LINE_BITS-1:0] line,
                                                  input logic [IDX_W-1:0]     idx);
        return line[int'(idx)*WORD_W +: WORD_W];
    endfunction

    // Word index lands in the offset field, so the address can never carry out of the line.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [BASE_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
        return {base, idx, {(OFFSET_BITS-IDX_W){1'b0}}};
    endfunction

`ifdef WB_DIRTY_MASK_EN
    logic [WORDS_PER_LINE-1:0] mask_q, mask_d, srch_mask;
    logic [IDX_W-1:0]          srch_cur, srch_idx;
    logic                      srch_incl, srch_vld;

    // In IDLE the encoder looks for the first dirty word of the incoming mask;
    // in WRITE it looks for the next dirty word after the current one.
    assign srch_incl = (state_q == WB_IDLE);
    assign srch_mask = srch_incl ? wbDirty : mask_q;
    assign srch_cur  = srch_incl ? '0 : idx_q;

    wb_next_dirty #(
        .WORDS_PER_LINE(WORDS_PER_LINE),
        .IDX_W(IDX_W)
    ) u_next_dirty (
        .mask(srch_mask),
        .cur_idx(srch_cur),
        .incl_cur(srch_incl),
        .nxt_idx(srch_idx),
        .nxt_vld(srch_vld)
    );

    assign first_idx = srch_idx;
    assign first_vld = srch_vld;
    assign next_idx  = srch_idx;
    assign next_vld  = srch_vld;

    always_comb begin
        mask_d = mask_q;
        if ((state_q == WB_IDLE) && wbStart) begin
            mask_d = wbDirty;
        end
    end

    always_ff @(posedge CLK) begin
        mask_q <= mask_d;
    end
`else
    assign first_idx = '0;
    assign first_vld = 1'b1;
    assign next_idx  = idx_q + IDX_W'(1);
    assign next_vld  = (idx_q != IDX_W'(WORDS_PER_LINE - 1));
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        line_d     = line_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        case (state_q)
            WB_IDLE: begin
                if (wbStart) begin
                    line_d = wbLine;
                    base_d = wbAddr[ADDR_W-1:OFFSET_BITS];
                    if (first_vld) begin
                        state_d    = WB_WRITE;
                        idx_d      = first_idx;
                        mem_addr_d = addr_of(wbAddr[ADDR_W-1:OFFSET_BITS], first_idx);
                        mem_dout_d = word_of(wbLine, first_idx);
                    end else begin
                        state_d = WB_DONE;
                        idx_d   = '0;
                    end
                end
            end
            WB_WRITE: begin
                if (memAck) begin
                    if (next_vld) begin
                        idx_d      = next_idx;
                        mem_addr_d = addr_of(base_q, next_idx);
                        mem_dout_d = word_of(line_q, next_idx);
                    end else begin
                        state_d = WB_DONE;
                    end
                end
            end
            WB_DONE: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // Reset aborts any transfer at once; line and base are data and need no reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= WB_IDLE;
            idx_q      <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
        end
        base_q <= base_d;
        line_q <= line_d;
    end

    assign memWE   = (state_q == WB_WRITE);
    assign wbBusy  = (state_q != WB_IDLE);
    assign wbDone  = (state_q == WB_DONE);
    assign memAddr = mem_addr_q;
    assign memDout = mem_dout_q;

endmodule

// File: tb/tb_cache_line_writeback.sv
// Directed bench for cache_line_writeback; dirty-mask cases run when WB_DIRTY_MASK_EN is set.
module tb_cache_line_writeback;

    logic         CLK = 1'b0;
    logic         RST;
    logic         wbStart;
    logic [31:0]  wbAddr;
    logic [255:0] wbLine;
`ifdef WB_DIRTY_MASK_EN
    logic [7:0]   wbDirty;
`endif
    logic         wbBusy, wbDone, memWE, memAck;
    logic [31:0]  memAddr, memDout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic        busy;
        logic        done;
        logic        chk_ad;
        logic [31:0] addr;
        logic [31:0] dout;
    } exp_t;

    exp_t burst_tbl[10];

    cache_line_writeback dut (
        .CLK(CLK),
        .RST(RST),
        .wbStart(wbStart),
        .wbAddr(wbAddr),
        .wbLine(wbLine),
`ifdef WB_DIRTY_MASK_EN
        .wbDirty(wbDirty),
`endif
        .wbBusy(wbBusy),
        .wbDone(wbDone),
        .memWE(memWE),
        .memAddr(memAddr),
        .memDout(memDout),
        .memAck(memAck)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] first);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = first + 32'(i);
        return l;
    endfunction

    task automatic start(input logic [31:0] addr, input logic [255:0] line);
        wbStart = 1'b1;
        wbAddr  = addr;
        wbLine  = line;
        tick();
        wbStart = 1'b0;
    endtask

    task automatic check_cycle(input string tag, input int cyc, input exp_t e);
        chk($sformatf("%s c%0d memWE", tag, cyc), 32'(memWE), 32'(e.we));
        chk($sformatf("%s c%0d wbBusy", tag, cyc), 32'(wbBusy), 32'(e.busy));
        chk($sformatf("%s c%0d wbDone", tag, cyc), 32'(wbDone), 32'(e.done));
        if (e.chk_ad) begin
            chk($sformatf("%s c%0d memAddr", tag, cyc), memAddr, e.addr);
            chk($sformatf("%s c%0d memDout", tag, cyc), memDout, e.dout);
        end
    endtask

    // Full 8-word burst at 0x1040 with words 0xA0..0xA7, memAck held high.
    task automatic run_burst(input string tag, input logic inject_start);
        start(32'h0000_1040, mk_line(32'hA0));
        for (int c = 0; c < 10; c++) begin
            check_cycle(tag, c + 1, burst_tbl[c]);
            if (inject_start && (c == 3)) begin
                wbStart = 1'b1;
                wbAddr  = 32'h0000_2000;
                wbLine  = mk_line(32'hB0);
            end else begin
                wbStart = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        int seq [11];
        exp_t e;

        for (int i = 0; i < 8; i++)
            burst_tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1040 + 32'(4*i), 32'hA0 + 32'(i)};
        burst_tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        burst_tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        seq = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};

        RST     = 1'b1;
        wbStart = 1'b0;
        wbAddr  = '0;
        wbLine  = '0;
        memAck  = 1'b0;
`ifdef WB_DIRTY_MASK_EN
        wbDirty = 8'hFF;
`endif
        tick();
        tick();
        check_cycle("reset", 0, '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
        RST = 1'b0;
        memAck = 1'b1;
        tick();

        run_burst("basic", 1'b0);
        run_burst("restart_ignored", 1'b1);

        start(32'h1234_567C, mk_line(32'hC0));
        check_cycle("unaligned", 1, '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5660, 32'hC0});
        for (int i = 0; i < 7; i++) tick();
        check_cycle("unaligned", 8, '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_567C, 32'hC7});
        tick();
        check_cycle("unaligned", 9, '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0});
        tick();

        // Word 2 is stalled for three cycles before being accepted.
        start(32'h0000_1040, mk_line(32'hA0));
        for (int c = 1; c <= 11; c++) begin
            memAck = !(c >= 3 && c <= 5);
            e = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1040 + 32'(4*seq[c-1]), 32'hA0 + 32'(seq[c-1])};
            check_cycle("stall", c, e);
            tick();
        end
        memAck = 1'b1;
        check_cycle("stall", 12, '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0});
        tick();
        check_cycle("stall", 13, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});

        // Reset asserted during cycle 5 of a burst.
        start(32'h0000_1040, mk_line(32'hA0));
        for (int i = 0; i < 4; i++) tick();
        check_cycle("abort", 5, '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1050, 32'hA4});
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_cycle("abort", 6, '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
        tick();
        check_cycle("abort", 7, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        run_burst("after_abort", 1'b0);

`ifdef WB_DIRTY_MASK_EN
        wbDirty = 8'b1000_0001;
        start(32'h0000_1040, mk_line(32'hA0));
        wbDirty = 8'hFF;
        check_cycle("dirty81", 1, '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1040, 32'hA0});
        tick();
        check_cycle("dirty81", 2, '{1'b1, 1'b1, 1'b0, 1'b1, 32'h105C, 32'hA7});
        tick();
        check_cycle("dirty81", 3, '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0});
        tick();
        check_cycle("dirty81", 4, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        wbDirty = 8'h00;
        start(32'h0000_1040, mk_line(32'hA0));
        wbDirty = 8'hFF;
        check_cycle("dirty00", 1, '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0});
        tick();
        check_cycle("dirty00", 2, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
